// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the FSM state encoding, port IDs and the round-robin pick helper.
package mem_arb_pkg;

  localparam int MEM_LAT_DEFAULT = 2;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // A lone requester always wins; on a tie the port not served last wins.
  function automatic port_e rr_pick(input logic ireq, input logic dreq, input port_e last);
    if (ireq && dreq) return (last == PORT_I) ? PORT_D : PORT_I;
    else if (dreq)    return PORT_D;
    else              return PORT_I;
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Down-counter that times the WAIT phase of a memory access.
// Load takes priority over decrement; zero_o flags an expired count.
module mem_lat_counter
  import mem_arb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                     cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between an
// instruction read port and a data read/write port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          IReq,
  input  logic [AW-1:0] IAddr,
  output logic          IAck,
  output logic [DW-1:0] IData,
  input  logic          DReq,
  input  logic          DWr,
  input  logic [AW-1:0] DAddr,
  input  logic [DW-1:0] DWData,
  output logic          DAck,
  output logic [DW-1:0] DData,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemDataIn,
  output logic          MemRD,
  output logic          MemWR,
  input  logic [DW-1:0] MemDataOut,
  output logic          Busy,
  output state_e        dbg_state_o
);

  // Handshake: a requester raises Req with a stable payload and holds it
  // until its one-cycle Ack. The payload is latched on the grant edge, so it
  // may change freely afterwards; Req is only looked at while IDLE.

  state_e          state_q;
  port_e           last_grant_q;
  port_e           pick;
  logic            wr_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            mem_rd_q, mem_wr_q;
  logic            iack_q, dack_q;
  logic [DW-1:0]   idata_q, ddata_q;
  logic            cnt_zero;

  assign pick = rr_pick(IReq, DReq, last_grant_q);

  // Loaded with MEM_LAT-1 so that WAIT spans exactly MEM_LAT cycles.
  mem_lat_counter u_lat_cnt (
    .clk_i      (Clk),
    .rst_i      (Rst),
    .load_i     (state_q == S_ISSUE),
    .load_val_i (CNT_W'(MEM_LAT - 1)),
    .dec_i      (state_q == S_WAIT && !cnt_zero),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= PORT_I;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      iack_q       <= 1'b0;
      dack_q       <= 1'b0;
      idata_q      <= '0;
      ddata_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (IReq || DReq) begin
            last_grant_q <= pick;
            if (pick == PORT_D) begin
              addr_q  <= DAddr;
              wr_q    <= DWr;
              wdata_q <= DWData;
              mem_rd_q <= !DWr;
              mem_wr_q <= DWr;
            end else begin
              addr_q  <= IAddr;
              wr_q    <= 1'b0;
              wdata_q <= '0;
              mem_rd_q <= 1'b1;
              mem_wr_q <= 1'b0;
            end
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_zero) begin
            if (last_grant_q == PORT_D) begin
              dack_q <= 1'b1;
              if (!wr_q) ddata_q <= MemDataOut;
            end else begin
              iack_q  <= 1'b1;
              idata_q <= MemDataOut;
            end
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          iack_q  <= 1'b0;
          dack_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign IAck        = iack_q;
  assign DAck        = dack_q;
  assign IData       = idata_q;
  assign DData       = ddata_q;
  assign MemAddr     = addr_q;
  assign MemDataIn   = wdata_q;
  assign MemRD       = mem_rd_q;
  assign MemWR       = mem_wr_q;
  assign Busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule
